h264invdc_transform: RTL and testbench
======================================

H264INVDC_TRANSFORM -- requirements
Module: h264invdc_transform

Interface
REQ-001 SHALL have ports, one per line (name, direction, width, meaning):
  CLK  in  1  single clock; all state updates on rising edge
  RESET  in  1  asynchronous reset, active-high
  ENABLE  in  1  input strobe; one coefficient row accepted per cycle with ENABLE=1 and READY=1
  DIN0..DIN3  in  16 each  signed coefficient row, DIN0 = column 0
  READY  out  1  block can accept a row this cycle
  VALID  out  1  DOUT0..DOUT3 carry a valid output beat
  LAST  out  1  marks output beat 3 of a block
  DOUT0..DOUT3  out  20 each  signed result column, DOUT0 = row 0
REQ-002 SHALL use one clock. Reset is asynchronous and active-high (fixed).
REQ-003 SHALL have parameters, one per line (name, default, meaning):
  IN_W  16  input coefficient width
  OUT_W  20  output width, equal to IN_W+4

Function
REQ-004 SHALL compute F = H*C*H, the inverse 4x4 luma-DC Hadamard. Rows of H: [1 1 1 1], [1 1 -1 -1], [1 -1 -1 1], [1 -1 1 -1]. No rounding, shift or dequantisation.
REQ-005 SHALL use an 8-state FSM: LOAD0..LOAD3, OUT0..OUT3. The reset state is LOAD0.
REQ-006 In LOADk: READY=1. ENABLE=1 moves to the next state (LOAD3 goes to OUT0). ENABLE=0 holds the state, for any gap length.
REQ-007 On acceptance in LOADk, SHALL store row k after the row pass (1-D butterfly of DIN0..3, IN_W+2 bits) into the 4x4 row-result array.
REQ-008 OUTj states SHALL each last exactly one cycle, move unconditionally (OUT3 goes to LOAD0), and hold READY=0. ENABLE SHALL be ignored in OUT states.
REQ-009 In OUTj: SHALL apply the column butterfly to column j of the array and register the result into DOUT0..3 at the cycle end. VALID is registered to 1, and LAST is registered to 1 only for j=3.
REQ-010 Latency: the first output beat SHALL be visible after the first rising edge following acceptance of row 3. VALID SHALL stay high for exactly 4 consecutive cycles, carrying columns 0,1,2,3 of F.
REQ-011 The output beat for column 3 is visible while the state is LOAD0. A row 0 accepted in that cycle SHALL NOT corrupt the displayed beat or the next block.
REQ-012 Throughput: at most one block per 8 cycles.
REQ-013 When VALID=0, DOUT0..3 SHALL hold their last value. LAST SHALL be 0 whenever VALID=0.
REQ-014 Arithmetic SHALL be signed two's complement, sign-extended at each stage. Full-range inputs SHALL never overflow OUT_W.

Reset
REQ-015 RESET=1 SHALL asynchronously force: state=LOAD0, READY=1 once released, VALID=0, LAST=0, DOUT0..3=0, and the array cleared to 0.
REQ-016 Reset mid-load or mid-output SHALL abandon the block. No partial beats SHALL follow, and the next accepted row is row 0.

Structure
REQ-017 Package h264invdc_pkg SHALL hold IN_W/OUT_W defaults, the FSM state enum, and the H-matrix sign constants.
REQ-018 SHALL contain one combinational sub-module, h264invdc_hadamard4 (4-point butterfly, width-parameterised). It is instantiated twice: row pass at IN_W, column pass at IN_W+2.

Verification
REQ-019 All C[i][j]=1, 4 back-to-back rows -> beat0 = {16,0,0,0}, beats 1-3 all 0, LAST on beat 3 only.
REQ-020 C[0][0]=5, rest 0 -> all 16 outputs = 5. VALID high 4 cycles, READY low during OUT0..OUT3.
REQ-021 All inputs +32767 -> F[0][0]=524272, others 0. All inputs -32768 -> F[0][0]=-524288. No wrap.
REQ-022 ENABLE gaps of 0, 1 and 3 cycles between rows; ENABLE held high during OUT states -> identical F, no extra row accepted.
REQ-023 RESET pulsed after row 2 accepted -> VALID stays 0. A fresh 4-row block with C[0][0]=5 -> all outputs 5.
REQ-024 Two blocks streamed with row 0 of block 2 presented in the beat-3 cycle -> both blocks' results correct, 8-cycle spacing.

Source files
------------

// File: rtl/h264invdc_pkg.sv
// Shared widths, FSM state encoding and Hadamard sign pattern for the luma-DC inverse transform.
// Pure declarations: no latency and no flow control of its own.
package h264invdc_pkg;

  localparam int IN_W_DEF  = 16;
  localparam int OUT_W_DEF = 20;

  typedef enum logic [2:0] {
    ST_LOAD0 = 3'd0,
    ST_LOAD1 = 3'd1,
    ST_LOAD2 = 3'd2,
    ST_LOAD3 = 3'd3,
    ST_OUT0  = 3'd4,
    ST_OUT1  = 3'd5,
    ST_OUT2  = 3'd6,
    ST_OUT3  = 3'd7
  } state_e;

  // Bit k of entry i is set where H[i][k] = -1 (H is symmetric).
  localparam logic [3:0] H_NEG [4] = '{4'b0000, 4'b1100, 4'b0110, 4'b1010};

endpackage

// File: rtl/h264invdc_hadamard4.sv
// 4-point Hadamard butterfly, W-bit signed in, W+2-bit signed out.
// Purely combinational: zero latency, no flow control.
module h264invdc_hadamard4
  import h264invdc_pkg::*;
#(
  parameter int W = IN_W_DEF
) (
  input  logic signed [W-1:0] x_i [4],
  output logic signed [W+1:0] y_o [4]
);

  logic signed [W+1:0] ext [4];

  for (genvar k = 0; k < 4; k++) begin : g_ext
    assign ext[k] = {{2{x_i[k][W-1]}}, x_i[k]};
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      y_o[i] = '0;
      for (int k = 0; k < 4; k++) begin
        if (H_NEG[i][k]) y_o[i] = y_o[i] - ext[k];
        else             y_o[i] = y_o[i] + ext[k];
      end
    end
  end

endmodule

// File: rtl/h264invdc_transform.sv
// Inverse 4x4 luma-DC Hadamard: four rows in, four column beats out one cycle after row 3.
// READY drops for the four output cycles, so at most one block is taken every 8 cycles.
module h264invdc_transform
  import h264invdc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic signed [IN_W-1:0]  DIN0,
  input  logic signed [IN_W-1:0]  DIN1,
  input  logic signed [IN_W-1:0]  DIN2,
  input  logic signed [IN_W-1:0]  DIN3,
  output logic                    READY,
  output logic                    VALID,
  output logic                    LAST,
  output logic signed [OUT_W-1:0] DOUT0,
  output logic signed [OUT_W-1:0] DOUT1,
  output logic signed [OUT_W-1:0] DOUT2,
  output logic signed [OUT_W-1:0] DOUT3
);

  state_e state_q, state_d;
  logic   is_load, accept;
  logic   [1:0] sel;

  logic signed [IN_W-1:0]  row_in  [4];
  logic signed [IN_W+1:0]  row_res [4];
  logic signed [IN_W+1:0]  arr_q   [4][4];
  logic signed [IN_W+1:0]  col_in  [4];
  logic signed [IN_W+3:0]  col_res [4];
  logic signed [OUT_W-1:0] dout_q  [4];
  logic                    valid_q, last_q;

  assign is_load = ~state_q[2];
  assign accept  = is_load & ENABLE;
  assign sel     = state_q[1:0];

  assign row_in[0] = DIN0;
  assign row_in[1] = DIN1;
  assign row_in[2] = DIN2;
  assign row_in[3] = DIN3;

  for (genvar k = 0; k < 4; k++) begin : g_col
    assign col_in[k] = arr_q[k][sel];
  end

  h264invdc_hadamard4 #(.W(IN_W)) u_row (
    .x_i (row_in),
    .y_o (row_res)
  );

  h264invdc_hadamard4 #(.W(IN_W + 2)) u_col (
    .x_i (col_in),
    .y_o (col_res)
  );

  // LOAD3 + 1 lands on OUT0 and OUT3 + 1 wraps to LOAD0 by encoding.
  always_comb begin
    state_d = state_q;
    if (!is_load || ENABLE) state_d = state_e'(3'(state_q + 3'd1));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_LOAD0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        dout_q[i] <= '0;
        for (int k = 0; k < 4; k++) arr_q[i][k] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= ~is_load;
      last_q  <= (state_q == ST_OUT3);
      if (!is_load) begin
        for (int i = 0; i < 4; i++) dout_q[i] <= OUT_W'(col_res[i]);
      end
      if (accept) begin
        for (int k = 0; k < 4; k++) arr_q[sel][k] <= row_res[k];
      end
    end
  end

  assign READY = is_load;
  assign VALID = valid_q;
  assign LAST  = last_q;
  assign DOUT0 = dout_q[0];
  assign DOUT1 = dout_q[1];
  assign DOUT2 = dout_q[2];
  assign DOUT3 = dout_q[3];

endmodule

// File: tb/tb_h264invdc_transform.sv
// Directed and random blocks checked against a matrix-product model of F = H*C*H.
module tb_h264invdc_transform;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               ENABLE;
  logic signed [15:0] DIN0, DIN1, DIN2, DIN3;
  logic               READY, VALID, LAST;
  logic signed [19:0] DOUT0, DOUT1, DOUT2, DOUT3;

  h264invdc_transform #(.IN_W(16), .OUT_W(20)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .DIN0   (DIN0),
    .DIN1   (DIN1),
    .DIN2   (DIN2),
    .DIN3   (DIN3),
    .READY  (READY),
    .VALID  (VALID),
    .LAST   (LAST),
    .DOUT0  (DOUT0),
    .DOUT1  (DOUT1),
    .DOUT2  (DOUT2),
    .DOUT3  (DOUT3)
  );

  always #5 CLK = ~CLK;

  int                 errors = 0;
  int                 checks = 0;
  int                 cm [4][4];
  longint             fm [4][4];
  int                 gap [4];
  bit                 en_hold;
  logic signed [19:0] last_beat [4];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int h(input int i, input int k);
    case (i)
      0:       return 1;
      1:       return (k < 2) ? 1 : -1;
      2:       return (k == 0 || k == 3) ? 1 : -1;
      default: return (k == 0 || k == 2) ? 1 : -1;
    endcase
  endfunction

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  task automatic model();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        fm[i][j] = 0;
        for (int k = 0; k < 4; k++)
          for (int l = 0; l < 4; l++)
            fm[i][j] += longint'(h(i, k)) * longint'(cm[k][l]) * longint'(h(l, j));
      end
  endtask

  task automatic fill(input int mode, input int v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        case (mode)
          0:       cm[i][j] = v;
          1:       cm[i][j] = (i == 0 && j == 0) ? v : 0;
          default: cm[i][j] = rnd16();
        endcase
  endtask

  task automatic rand_din();
    DIN0 = 16'($urandom); DIN1 = 16'($urandom); DIN2 = 16'($urandom); DIN3 = 16'($urandom);
  endtask

  task automatic set_din(input int r);
    DIN0 = 16'(cm[r][0]); DIN1 = 16'(cm[r][1]); DIN2 = 16'(cm[r][2]); DIN3 = 16'(cm[r][3]);
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_valid"}, VALID, 1'b0);
    chk({tag, "_last"}, LAST, 1'b0);
    chk({tag, "_d0"}, DOUT0, last_beat[0]);
    chk({tag, "_d3"}, DOUT3, last_beat[3]);
  endtask

  // Entered and left right after a falling edge; returns during the beat-3 cycle.
  task automatic run_block();
    model();
    for (int r = 0; r < 4; r++) begin
      for (int g = 0; g < gap[r]; g++) begin
        chk("gap_ready", READY, 1'b1);
        ENABLE = 1'b0;
        rand_din();
        @(negedge CLK);
      end
      chk("row_ready", READY, 1'b1);
      if (r > 0) chk_held("row");
      ENABLE = 1'b1;
      set_din(r);
      @(negedge CLK);
    end
    chk("out0_ready", READY, 1'b0);
    chk("out0_valid", VALID, 1'b0);
    ENABLE = en_hold;
    rand_din();
    @(negedge CLK);
    for (int j = 0; j < 4; j++) begin
      chk("beat_valid", VALID, 1'b1);
      chk("beat_last", LAST, j == 3);
      chk("beat_ready", READY, j == 3);
      chk("beat_d0", DOUT0, fm[0][j]);
      chk("beat_d1", DOUT1, fm[1][j]);
      chk("beat_d2", DOUT2, fm[2][j]);
      chk("beat_d3", DOUT3, fm[3][j]);
      last_beat[0] = 20'(fm[0][j]); last_beat[1] = 20'(fm[1][j]);
      last_beat[2] = 20'(fm[2][j]); last_beat[3] = 20'(fm[3][j]);
      if (j < 3) begin
        ENABLE = en_hold;
        rand_din();
        @(negedge CLK);
      end
    end
    ENABLE = 1'b0;
  endtask

  task automatic idle_check();
    ENABLE = 1'b0;
    @(negedge CLK);
    chk_held("idle");
  endtask

  task automatic rows_only(input int n);
    for (int r = 0; r < n; r++) begin
      ENABLE = 1'b1;
      set_din(r);
      @(negedge CLK);
    end
    ENABLE = 1'b0;
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    #1;
    chk("rst_valid", VALID, 1'b0);
    chk("rst_last", LAST, 1'b0);
    chk("rst_d0", DOUT0, 20'sd0);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) last_beat[i] = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("post_rst_valid", VALID, 1'b0);
      chk("post_rst_ready", READY, 1'b1);
    end
  endtask

  initial begin
    RESET = 1'b1;
    ENABLE = 1'b0;
    DIN0 = '0; DIN1 = '0; DIN2 = '0; DIN3 = '0;
    for (int i = 0; i < 4; i++) begin
      last_beat[i] = '0;
      gap[i] = 0;
    end
    en_hold = 1'b0;
    @(negedge CLK);
    chk("reset_valid", VALID, 1'b0);
    chk("reset_last", LAST, 1'b0);
    chk("reset_d0", DOUT0, 20'sd0);
    chk("reset_d1", DOUT1, 20'sd0);
    chk("reset_d2", DOUT2, 20'sd0);
    chk("reset_d3", DOUT3, 20'sd0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("reset_ready", READY, 1'b1);

    fill(0, 1);
    run_block();
    chk("ones_f00", last_beat[0], 20'sd0);
    idle_check();

    fill(1, 5);
    run_block();
    chk("dc5_f33", DOUT3, 20'sd5);
    idle_check();

    fill(0, 32767);
    run_block();
    idle_check();
    fill(0, -32768);
    run_block();
    idle_check();

    gap[0] = 0; gap[1] = 1; gap[2] = 3; gap[3] = 2;
    en_hold = 1'b1;
    for (int b = 0; b < 4; b++) begin
      fill(2, 0);
      run_block();
      idle_check();
    end
    fill(0, 7);
    run_block();
    idle_check();

    for (int i = 0; i < 4; i++) gap[i] = 0;
    en_hold = 1'b0;
    fill(2, 0);
    run_block();
    fill(2, 0);
    run_block();
    fill(2, 0);
    run_block();
    idle_check();

    fill(2, 0);
    rows_only(3);
    pulse_reset();
    fill(1, 5);
    run_block();
    idle_check();

    fill(2, 0);
    rows_only(4);
    @(negedge CLK);
    chk("midout_valid", VALID, 1'b1);
    pulse_reset();
    fill(2, 0);
    run_block();
    idle_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
